// File: rtl/ofcu_ctrl_if.sv
// ofcu_ctrl_if: command, byte-stream and SRAM bus bundle for the page copy controller.
// The master side is the host/SRAM environment; the slave side is the controller.
interface ofcu_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [5:0]  cmd_page;
    logic        abort;
    logic [7:0]  byte_in;
    logic        byte_in_valid;
    logic        byte_in_ready;
    logic [7:0]  byte_out;
    logic        byte_out_valid;
    logic        byte_out_ready;
    logic [16:0] sram_addr;
    logic [15:0] sram_wdata;
    logic        sram_we;
    logic        sram_re;
    logic [15:0] sram_rdata;
    logic        busy;
    logic        done;
    modport master (
        output cmd_valid, cmd_write, cmd_page, abort, byte_in, byte_in_valid, byte_out_ready, sram_rdata,
        input  cmd_ready, byte_in_ready, byte_out, byte_out_valid, sram_addr, sram_wdata, sram_we, sram_re,
               busy, done
    );
    modport slave (
        input  cmd_valid, cmd_write, cmd_page, abort, byte_in, byte_in_valid, byte_out_ready, sram_rdata,
        output cmd_ready, byte_in_ready, byte_out, byte_out_valid, sram_addr, sram_wdata, sram_we, sram_re,
               busy, done
    );
endinterface

// File: rtl/ofcu_ctrl.sv
// ofcu_ctrl: moves one page between a byte stream and a 16-bit off-chip SRAM, big-endian byte order.
module ofcu_ctrl #(
    parameter int PAGE_WORDS = 528
) (
    input logic       clk2,
    input logic       NReset,
    ofcu_ctrl_if.slave bus
);
    typedef enum logic [3:0] {IDLE, ST_HI, ST_LO, ST_WR, FE_RD, FE_CAP, FE_HI, FE_LO, DONE} state_t;
    localparam logic [9:0] LAST = 10'(PAGE_WORDS - 1);
    state_t      state, state_n;
    logic [9:0]  word_idx;
    logic [16:0] base;
    logic [15:0] wdata, rbuf;
    logic        last, in_hs, out_hs, accept, kill;
    assign last   = word_idx == LAST;
    assign in_hs  = bus.byte_in_valid && bus.byte_in_ready;
    assign out_hs = bus.byte_out_valid && bus.byte_out_ready;
    assign accept = state == IDLE && bus.cmd_valid;
    assign kill   = bus.abort && state != IDLE;
    assign bus.cmd_ready      = state == IDLE;
    assign bus.busy           = state != IDLE;
    assign bus.done           = state == DONE;
    assign bus.sram_we        = state == ST_WR;
    assign bus.sram_re        = state == FE_RD;
    assign bus.byte_in_ready  = state == ST_HI || state == ST_LO;
    assign bus.byte_out_valid = state == FE_HI || state == FE_LO;
    assign bus.byte_out       = state == FE_HI ? rbuf[15:8] : rbuf[7:0];
    assign bus.sram_addr      = base + {7'd0, word_idx};
    assign bus.sram_wdata     = wdata;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.cmd_valid) state_n = bus.cmd_write ? ST_HI : FE_RD;
            ST_HI:   if (in_hs) state_n = ST_LO;
            ST_LO:   if (in_hs) state_n = ST_WR;
            ST_WR:   state_n = last ? DONE : ST_HI;
            FE_RD:   state_n = FE_CAP;
            FE_CAP:  state_n = FE_HI;
            FE_HI:   if (out_hs) state_n = FE_LO;
            FE_LO:   if (out_hs) state_n = last ? DONE : FE_RD;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (kill) state_n = IDLE;
    end
    always_ff @(posedge clk2 or negedge NReset) begin
        if (!NReset) begin
            state    <= IDLE;
            word_idx <= '0;
            base     <= '0;
            wdata    <= '0;
            rbuf     <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                base     <= 17'(bus.cmd_page) * 17'(PAGE_WORDS);
                word_idx <= '0;
            end
            // abort wins: a half-captured word or pending read is simply dropped
            if (!kill) begin
                if (state == ST_HI && in_hs) wdata[15:8] <= bus.byte_in;
                if (state == ST_LO && in_hs) wdata[7:0] <= bus.byte_in;
                if (state == FE_CAP) rbuf <= bus.sram_rdata;
                if (!last && (state == ST_WR || (state == FE_LO && out_hs))) word_idx <= word_idx + 10'd1;
            end
        end
    end
endmodule

// File: tb/tb_ofcu_ctrl.sv
// tb_ofcu_ctrl: directed checks of page STORE/FETCH, abort, reset and back-to-back commands.
module tb_ofcu_ctrl;
    logic clk2 = 1'b0;
    logic NReset = 1'b0;
    always #5 clk2 = ~clk2;
    ofcu_ctrl_if bus();
    ofcu_ctrl #(.PAGE_WORDS(528)) dut (.clk2(clk2), .NReset(NReset), .bus(bus));
    int checks = 0, failures = 0;
    int n_wr, n_re, n_done, wd_err, excl_err = 0, n_out, cnt, kd, re_snap, berr;
    logic [16:0] last_wa, max_wa, first_wa, exp_base, hit_addr, off;
    logic [15:0] first_wd;
    logic [9:0] w;
    logic [7:0] e;
    bit hit, tog;
    logic [7:0] ob [0:1055];
    // SRAM read data appears the cycle after the read strobe, carrying its own address
    always @(posedge clk2) if (bus.sram_re) bus.sram_rdata <= bus.sram_addr[15:0];
    always @(negedge clk2) begin
        if (bus.sram_we) begin
            if (n_wr == 0) begin
                first_wa = bus.sram_addr;
                first_wd = bus.sram_wdata;
            end
            n_wr++;
            last_wa = bus.sram_addr;
            if (bus.sram_addr > max_wa) max_wa = bus.sram_addr;
            if (bus.sram_addr == hit_addr) hit = 1'b1;
            off = bus.sram_addr - exp_base;
            if (bus.sram_wdata !== {off[6:0], 1'b0, off[6:0], 1'b1}) wd_err++;
        end
        if (bus.sram_re) n_re++;
        if (bus.done) n_done++;
        if (bus.sram_we && bus.sram_re) excl_err++;
    end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask
    task automatic clear(input logic [16:0] b, input logic [16:0] h);
        n_wr = 0; n_re = 0; n_done = 0; wd_err = 0; max_wa = '0; hit = 1'b0;
        exp_base = b; hit_addr = h;
    endtask
    task automatic issue(input bit wr, input logic [5:0] pg);
        bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_page = pg;
        cnt = 0; tog = 1'b1; n_out = 0;
        @(posedge clk2);
        @(negedge clk2);
        bus.cmd_valid = 1'b0;
    endtask
    task automatic stream(input int max, input bit ab5, output int kdone);
        kdone = -1;
        for (int k = 0; k < max; k++) begin
            if (bus.done) begin
                kdone = k;
                return;
            end
            if (ab5 && bus.byte_in_ready && cnt == 11) begin
                bus.abort = 1'b1;
                @(negedge clk2);
                bus.abort = 1'b0;
                return;
            end
            if (bus.byte_in_ready) begin
                bus.byte_in = 8'(cnt);
                cnt++;
            end
            bus.byte_out_ready = tog;
            tog = ~tog;
            if (bus.byte_out_valid && bus.byte_out_ready && n_out < 1056) begin
                ob[n_out] = bus.byte_out;
                n_out++;
            end
            @(negedge clk2);
        end
    endtask
    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_page = 0; bus.abort = 0;
        bus.byte_in = 0; bus.byte_in_valid = 1; bus.byte_out_ready = 0; bus.sram_rdata = 0;
        clear(17'd0, '1);
        #2;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        check("rst_outputs", 32'({bus.busy, bus.done, bus.sram_we, bus.sram_re, bus.byte_in_ready, bus.byte_out_valid}), 0);
        @(negedge clk2);
        NReset = 1'b1;
        @(negedge clk2);
        clear(17'd1056, '1);
        issue(1'b1, 6'd2);
        stream(3000, 1'b0, kd);
        check("st2_done_cycle", kd, 1584);
        check("st2_writes", n_wr, 528);
        check("st2_first_addr", 32'(first_wa), 1056);
        check("st2_first_data", 32'(first_wd), 32'h0001);
        check("st2_last_addr", 32'(last_wa), 1583);
        check("st2_data_errors", wd_err, 0);
        @(negedge clk2);
        check("st2_idle_ready", 32'(bus.cmd_ready), 1);
        check("st2_done_count", n_done, 1);
        clear(17'd528, 17'd533);
        issue(1'b1, 6'd1);
        stream(100, 1'b1, kd);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_writes", n_wr, 5);
        check("abort_no_w5", 32'(hit), 0);
        repeat (3) @(negedge clk2);
        check("abort_no_done", n_done, 0);
        check("abort_ready", 32'(bus.cmd_ready), 1);
        clear(17'd0, '1);
        issue(1'b0, 6'd0);
        check("fe0_accept", 32'({bus.busy, bus.sram_re}), 32'b11);
        stream(8000, 1'b0, kd);
        check("fe0_done_seen", 32'(kd > 0), 1);
        check("fe0_bytes", n_out, 1056);
        check("fe0_first4", {ob[0], ob[1], ob[2], ob[3]}, 32'h00000001);
        check("fe0_last_pair", 32'({ob[1054], ob[1055]}), 32'h020F);
        berr = 0;
        for (int i = 0; i < 1056; i++) begin
            w = 10'(i / 2);
            e = (i % 2 == 1) ? w[7:0] : {6'd0, w[9:8]};
            if (ob[i] !== e) berr++;
        end
        check("fe0_byte_errors", berr, 0);
        check("fe0_reads", n_re, 528);
        repeat (4) @(negedge clk2);
        check("fe0_done_count", n_done, 1);
        clear(17'd33264, 17'd33792);
        issue(1'b1, 6'd63);
        stream(3000, 1'b0, kd);
        check("st63_last_addr", 32'(last_wa), 33791);
        check("st63_max_addr", 32'(max_wa), 33791);
        check("st63_writes", n_wr, 528);
        check("st63_above", 32'(hit), 0);
        check("st63_data_errors", wd_err, 0);
        @(negedge clk2);
        clear(17'd2640, '1);
        issue(1'b0, 6'd5);
        bus.byte_out_ready = 1'b0;
        for (int i = 0; i < 10 && !bus.byte_out_valid; i++) @(negedge clk2);
        check("rst_fe_hi_reached", 32'(bus.byte_out_valid), 1);
        NReset = 1'b0;
        #1;
        check("rst_mid_outputs", 32'({bus.byte_out_valid, bus.cmd_ready, bus.busy}), 32'b010);
        re_snap = n_re;
        @(negedge clk2);
        NReset = 1'b1;
        repeat (5) @(negedge clk2);
        check("rst_mid_no_re", n_re, re_snap);
        check("rst_mid_no_done", n_done, 0);
        clear(17'd2112, '1);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_page = 6'd4; cnt = 0;
        @(posedge clk2);
        @(negedge clk2);
        stream(3000, 1'b0, kd);
        check("held_done_cycle", kd, 1584);
        @(negedge clk2);
        check("held_idle", 32'({bus.cmd_ready, bus.busy}), 32'b10);
        @(negedge clk2);
        check("held_reaccept", 32'({bus.busy, bus.byte_in_ready}), 32'b11);
        bus.cmd_valid = 1'b0; bus.abort = 1'b1;
        @(negedge clk2);
        bus.abort = 1'b0;
        check("held_abort", 32'(bus.busy), 0);
        bus.cmd_valid = 1'b1; bus.abort = 1'b1; bus.cmd_write = 1'b0; bus.cmd_page = 6'd0;
        @(posedge clk2);
        @(negedge clk2);
        bus.cmd_valid = 1'b0; bus.abort = 1'b0;
        check("abort_idle_accept", 32'({bus.busy, bus.sram_re}), 32'b11);
        bus.abort = 1'b1;
        @(negedge clk2);
        bus.abort = 1'b0;
        check("abort_idle_clear", 32'(bus.busy), 0);
        check("strobe_exclusive", excl_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ofcu_ctrl.md
OFCU_CTRL -- requirements
Module: ofcu_ctrl

Interface
REQ-001 Parameter PAGE_WORDS, default 528, meaning 16-bit words per page (1056 bytes).
REQ-002 clk2  input  1  single clock; all state updates on its rising edge.
REQ-003 NReset  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid / cmd_ready  input / output  1 / 1  command handshake; a command transfers when both are 1 on a clock edge.
REQ-005 cmd_write  input  1  command type: 1 = STORE (bytes in, SRAM words written); 0 = FETCH (SRAM words read, bytes out).
REQ-006 cmd_page  input  6  page index 0..63; sampled with the command.
REQ-007 abort  input  1  synchronous abort of the active command.
REQ-008 byte_in[7:0], byte_in_valid  input  8, 1  STORE byte stream.
REQ-009 byte_in_ready  output  1  STORE byte stream ready.
REQ-010 byte_out[7:0], byte_out_valid  output  8, 1  FETCH byte stream.
REQ-011 byte_out_ready  input  1  FETCH byte stream ready.
REQ-012 sram_addr  output  17  off-chip SRAM word address.
REQ-013 sram_wdata  output  16  off-chip SRAM write data.
REQ-014 sram_we, sram_re  output  1, 1  SRAM write and read strobes; each strobe is one cycle per access.
REQ-015 sram_rdata  input  16  SRAM read data; valid exactly one cycle after the sram_re cycle.
REQ-016 busy, done  output  1, 1  busy = command active; done = 1-cycle completion pulse.

Function
REQ-017 FSM states: IDLE, ST_HI, ST_LO, ST_WR, FE_RD, FE_CAP, FE_HI, FE_LO, DONE.
REQ-018 cmd_ready is 1 only in IDLE; busy is 1 in every state except IDLE.
REQ-019 On command acceptance: latch base = cmd_page*PAGE_WORDS (17-bit unsigned) and word_idx = 0; go to ST_HI if cmd_write = 1, else go to FE_RD.
REQ-020 ST_HI: byte_in_ready = 1; on a byte_in handshake, capture the byte into wdata[15:8] and go to ST_LO.
REQ-021 ST_LO: byte_in_ready = 1; on a byte_in handshake, capture the byte into wdata[7:0] and go to ST_WR.
REQ-022 ST_WR: for exactly one cycle, assert sram_we = 1 with sram_addr = base + word_idx and sram_wdata = wdata.
REQ-023 ST_WR exit: if word_idx == PAGE_WORDS-1, go to DONE; otherwise increment word_idx and go to ST_HI.
REQ-024 FE_RD: for one cycle, assert sram_re = 1 with sram_addr = base + word_idx; go to FE_CAP.
REQ-025 FE_CAP: capture sram_rdata into rbuf; go to FE_HI.
REQ-026 FE_HI: byte_out = rbuf[15:8] and byte_out_valid = 1, held stable until byte_out_ready; on that handshake go to FE_LO.
REQ-027 FE_LO: byte_out = rbuf[7:0] and byte_out_valid = 1, held stable until byte_out_ready; on that handshake, if last word go to DONE, else increment word_idx and go to FE_RD.
REQ-028 Throughput ceiling: STORE takes 3 cycles per word and FETCH takes 4 cycles per word when streams never stall.
REQ-029 DONE: done = 1 for one cycle, then go to IDLE; a new command is accepted no earlier than the next cycle.
REQ-030 Strobe exclusivity: sram_we and sram_re are never 1 together.
REQ-031 Strobe placement: sram_we and sram_re are 0 outside ST_WR and FE_RD respectively.
REQ-032 byte_in_ready is 0 outside ST_HI/ST_LO; byte_out_valid is 0 outside FE_HI/FE_LO.
REQ-033 Abort: abort = 1 in any non-IDLE state forces IDLE on the next edge with no done pulse; a pending half word is discarded and not written.
REQ-034 abort in IDLE: no effect; abort is sampled with priority over every other transition.
REQ-035 abort and cmd_valid both 1 in IDLE: the command is accepted.
REQ-036 Address range: page 63, last word gives sram_addr = 63*528+527 = 33791; no address wrap occurs; word_idx is 10 bits.
REQ-037 sram_addr and sram_wdata may change freely when their strobes are 0.

Reset
REQ-038 NReset low forces asynchronously: state = IDLE; word_idx, base, wdata, rbuf = 0.
REQ-039 NReset low forces outputs: cmd_ready = 1 and busy = done = sram_we = sram_re = byte_in_ready = byte_out_valid = 0.
REQ-040 Reset asserted mid-command abandons the command with no SRAM strobe and no done pulse.

Verification
REQ-041 STORE page 2, bytes 0x00..0xFF repeating, no stalls -> first write: addr 1056, data 0x0001; 528 writes; last write addr 1583; done 1584 cycles after acceptance.
REQ-042 FETCH page 0, SRAM model returns addr as data, byte_out_ready toggling 1/0 -> bytes 0x00,0x00,0x00,0x01,...; last pair 0x02,0x0F; exactly one done pulse.
REQ-043 STORE page 63 -> last sram_addr = 33791; no write above 33791.
REQ-044 abort after the first byte of word 5 of a STORE -> no write at base+5; busy = 0 next cycle; no done pulse; next command accepted normally.
REQ-045 NReset pulsed low during FE_HI -> byte_out_valid drops immediately; cmd_ready = 1; no further sram_re.
REQ-046 cmd_valid held high through DONE -> second command accepted exactly one cycle after the done pulse; abort+cmd_valid in IDLE -> command accepted.
